// File: rtl/picorv_bus_pkg.sv
// Shared types for the PicoRV32 two-master bus arbiter: FSM states,
// master index and the default read data returned on a watchdog abort.
package picorv_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RECOVER = 2'd2
  } arb_state_t;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } master_idx_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // One-hot grant vector for a master index (bit0 = m0, bit1 = m1).
  function automatic logic [1:0] grant_onehot(input master_idx_t m);
    return (m == MST_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/picorv_arb_watchdog.sv
// Bus watchdog: counts cycles while run is high, restarts on clear and
// flags expired once the count has reached TIMEOUT (saturating).
module picorv_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT);

  logic [15:0] count;

  // Stall counter; holds at the limit so expired stays asserted until cleared.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != LIMIT)) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/picorv_bus_arbiter.sv
// Two-master round-robin arbiter in front of a shared PicoRV32-style memory.
// Optional bus watchdog enabled by defining PICORV_ARB_TIMEOUT_EN.
module picorv_bus_arbiter
  import picorv_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,
  output logic        s_mem_valid,
  output logic        s_mem_instr,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  arb_state_t  state, state_nxt;
  logic [1:0]  grant_q, grant_nxt;
  master_idx_t last_q, last_nxt;
  master_idx_t winner;
  master_idx_t owner;
  logic        any_req;
  logic        busy;
  logic        abort;
  logic        done;

  assign any_req = m0_mem_valid | m1_mem_valid;
  assign busy    = (state == ST_BUSY);
  assign owner   = grant_q[1] ? MST_M1 : MST_M0;

`ifdef PICORV_ARB_TIMEOUT_EN
  logic wd_expired;

  picorv_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .resetn (resetn),
    .clear  ((state == ST_IDLE) && any_req),
    .run    (busy && !s_mem_ready),
    .expired(wd_expired)
  );

  // A real ready in the expiry cycle wins over the abort.
  assign abort = busy && wd_expired && !s_mem_ready;

  // Sticky abort flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timeout_err <= 1'b0;
    end else if (abort) begin
      timeout_err <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg  = ^16'(TIMEOUT);
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign done = busy && (s_mem_ready || abort);

  // Round-robin pick: with both requesting, the one not served last wins.
  always_comb begin
    winner = MST_M1;
    if (m0_mem_valid && m1_mem_valid) begin
      winner = (last_q == MST_M1) ? MST_M0 : MST_M1;
    end else if (m0_mem_valid) begin
      winner = MST_M0;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      last_q  <= MST_M1;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
    end
  end

  // Next-state: grant in IDLE, release on completion, one RECOVER cycle.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    last_nxt  = last_q;
    unique case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant_nxt = grant_onehot(winner);
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (done) begin
          last_nxt  = owner;
          grant_nxt = '0;
          state_nxt = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Bus mux toward memory and ready/rdata steering back to the masters.
  always_comb begin
    s_mem_valid  = 1'b0;
    s_mem_instr  = 1'b0;
    s_mem_addr   = '0;
    s_mem_wdata  = '0;
    s_mem_wstrb  = '0;
    m0_mem_ready = 1'b0;
    m1_mem_ready = 1'b0;
    m0_mem_rdata = s_mem_rdata;
    m1_mem_rdata = s_mem_rdata;
    if (resetn && busy) begin
      if (owner == MST_M1) begin
        s_mem_valid = m1_mem_valid;
        s_mem_instr = m1_mem_instr;
        s_mem_addr  = m1_mem_addr;
        s_mem_wdata = m1_mem_wdata;
        s_mem_wstrb = m1_mem_wstrb;
      end else begin
        s_mem_valid = m0_mem_valid;
        s_mem_instr = m0_mem_instr;
        s_mem_addr  = m0_mem_addr;
        s_mem_wdata = m0_mem_wdata;
        s_mem_wstrb = m0_mem_wstrb;
      end
      if (abort) begin
        s_mem_valid = 1'b0;
      end
      m0_mem_ready = done && grant_q[0];
      m1_mem_ready = done && grant_q[1];
      if (abort && grant_q[0]) m0_mem_rdata = ERR_RDATA;
      if (abort && grant_q[1]) m1_mem_rdata = ERR_RDATA;
    end
  end

  assign grant = grant_q;

endmodule

// File: doc/picorv_bus_arbiter.md
PICORV_BUS_ARBITER -- requirements
Module: picorv_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the watchdog limit in clk cycles (range 1..65535).
REQ-002 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, giving the read data returned on a watchdog abort.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports m0_mem_valid / m1_mem_valid  input  1  master request.
REQ-006 SHALL have ports m0_mem_instr / m1_mem_instr  input  1  instruction-fetch flag.
REQ-007 SHALL have ports m0_mem_addr, m0_mem_wdata / m1_mem_addr, m1_mem_wdata  input  32  address and write data.
REQ-008 SHALL have ports m0_mem_wstrb / m1_mem_wstrb  input  4  byte write strobes (0 = read).
REQ-009 SHALL have ports m0_mem_ready / m1_mem_ready  output  1  per-master completion pulse.
REQ-010 SHALL have ports m0_mem_rdata / m1_mem_rdata  output  32  read data.
REQ-011 SHALL have ports s_mem_valid, s_mem_instr  output  1; s_mem_addr, s_mem_wdata  output  32; s_mem_wstrb  output  4; all toward the shared memory.
REQ-012 SHALL have ports s_mem_ready  input  1 and s_mem_rdata  input  32, from the shared memory.
REQ-013 SHALL have port grant  output  2  one-hot owner (bit0 = m0, bit1 = m1, 0 = none).
REQ-014 SHALL have port timeout_err  output  1  sticky watchdog-abort flag.

Function
REQ-015 SHALL implement the states IDLE, BUSY, and RECOVER.
REQ-016 SHALL, in IDLE with at least one valid master, register the winner into grant and move to BUSY on the next edge; arbitration latency is 1 cycle.
REQ-017 SHALL resolve simultaneous requests round-robin: the winner is the master not served last (last_grant); a single requester always wins.
REQ-018 SHALL, in BUSY, drive s_mem_* combinationally from the granted master's valid/instr/addr/wdata/wstrb; outside BUSY s_mem_valid SHALL be 0 and s_mem_* data SHALL be 0.
REQ-019 SHALL route s_mem_ready only to the granted master's mem_ready; the non-granted mem_ready SHALL be 0.
REQ-020 SHALL pass s_mem_rdata to both m*_mem_rdata.
REQ-021 SHALL, on s_mem_ready=1 in BUSY, set last_grant to the current owner, clear grant and enter RECOVER.
REQ-022 SHALL hold RECOVER for exactly 1 cycle and then enter IDLE, so a master's stale valid is never re-sampled.
REQ-023 SHALL keep a non-granted requester waiting with its signals ignored; it wins in the next IDLE cycle (worst-case wait: one transaction plus 2 cycles).
REQ-024 SHALL ignore s_mem_ready outside BUSY.

Reset
REQ-025 SHALL, while resetn=0 at a clock edge, set: state IDLE, grant 0, last_grant m1 (so m0 wins first), watchdog count 0, timeout_err 0.
REQ-026 SHALL, while resetn=0, drive all m*_mem_ready and s_mem_valid to 0.
REQ-027 SHALL, on reset mid-transaction, abandon the transaction with no ready pulse generated.

Configuration
REQ-028 SHALL, with PICORV_ARB_TIMEOUT_EN defined, count BUSY cycles without s_mem_ready.
REQ-029 SHALL, when that count reaches TIMEOUT, in the same cycle: pulse the owner's mem_ready, drive ERR_RDATA on that owner's rdata, force s_mem_valid to 0, set timeout_err, and enter RECOVER.
REQ-030 SHALL clear the watchdog count on entry to BUSY.
REQ-031 SHALL, without PICORV_ARB_TIMEOUT_EN, wait indefinitely in BUSY, tie timeout_err to 0, and instantiate no counter.

Structure
REQ-032 SHALL place the state enum (IDLE/BUSY/RECOVER), the master-index type and the default ERR_RDATA in shared package picorv_bus_pkg.
REQ-033 SHALL implement the watchdog as sub-module picorv_arb_watchdog (inputs: clk, resetn, clear, run; output: expired), instantiated only under PICORV_ARB_TIMEOUT_EN.

Verification
REQ-034 SHALL cover a single m0 read at 0x100, memory answering 2 cycles after s_mem_valid: m0_mem_ready pulses once, rdata passes through, m1_mem_ready stays 0, grant 01 -> 00.
REQ-035 SHALL cover m0 and m1 both valid right after reset: m0 is served first, then m1 after RECOVER+IDLE; grant sequence 01, 00, 00, 10.
REQ-036 SHALL cover both masters requesting continuously for 8 transactions: grants strictly alternate, 4 per master.
REQ-037 SHALL cover an m1 write (wstrb 4'hF, wdata 0x1234_5678) while m0 idle: s_mem_* equals the m1 values exactly in every BUSY cycle.
REQ-038 SHALL cover resetn low for 1 cycle during BUSY: grant 0, no ready pulse, and the next request arbitrates normally with m0 preferred.
REQ-039 SHALL cover, with PICORV_ARB_TIMEOUT_EN and TIMEOUT=4, memory never asserting ready: the owner's ready pulses with rdata DEADBEEF, timeout_err stays 1 until reset, and the arbiter returns to IDLE.
